rf_multiport: RTL and testbench

//  Parametrised multi-port integer register file; successor to the single-write/dual-read RF in the pipeline core.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_clear_seq.sv | 65 ++++++
 rtl/rf_multiport.sv | 108 ++++++++++
 tb/tb_rf_multiport.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types, limits and helpers for the multi-port register file.
// Latency: none (declarations only).
// Backpressure: none.
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_MAX_RD = 4;
    localparam int RF_MAX_WR = 2;

    // Address width for a register file of n entries.
    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every register index once after reset or on clr_req.
// Latency: one register per cycle, NREGS cycles per sweep; busy is registered state.
// Backpressure: clr_req is ignored while a sweep is running; rst restarts the sweep.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter  int NREGS = 32,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state_q;
    rf_state_e     state_d;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // State and sweep counter; reset parks the sequencer at the start of a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: start a sweep from IDLE on request, leave CLEAR after the last index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // While rst is held the sweep has not started, so only register 0 is cleared.
    assign busy     = (state_q == RF_CLEAR);
    assign clr_we   = rst | busy;
    assign clr_addr = rst ? '0 : cnt_q;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file with prioritised posedge writes and a clear sweep (optional RF_BYPASS_EN forwarding).
// Latency: reads are combinational; writes land at posedge (or forward same-cycle with RF_BYPASS_EN).
// Backpressure: none; writes arriving during a clear sweep or reset are dropped, and reads return 0.
module rf_multiport
    import rf_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int NWR      = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic                busy
);

    // Ports beyond the supported maximum are left inactive (their reads return 0).
    localparam int NRD_I = (NRD < RF_MAX_RD) ? NRD : RF_MAX_RD;
    localparam int NWR_I = (NWR < RF_MAX_WR) ? NWR : RF_MAX_WR;

    logic                  clr_we;
    logic [AW-1:0]         clr_addr;
    logic [NWR-1:0]        wen;
    logic [NREGS*XLEN-1:0] mem_flat;
    logic [AW-1:0]         ra;
    logic [XLEN-1:0]       rv;

    rf_clear_seq #(
        .NREGS    (NREGS)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Effective user write enables: dropped during clear/reset and for a hardwired zero register.
    always_comb begin
        wen = '0;
        for (int p = 0; p < NWR_I; p++) begin
            wen[p] = we[p] && !clr_we &&
                     !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] nxt;

        // Next value: clear port overrides users; later ports override earlier ones.
        always_comb begin
            nxt = q;
            if (clr_we) begin
                if (clr_addr == AW'(g)) begin
                    nxt = '0;
                end
            end else begin
                for (int p = 0; p < NWR_I; p++) begin
                    if (wen[p] && (wr_addr[p*AW +: AW] == AW'(g))) begin
                        nxt = wr_data[p*XLEN +: XLEN];
                    end
                end
            end
        end

        // Register storage.
        always_ff @(posedge clk) begin
            q <= nxt;
        end

        assign mem_flat[g*XLEN +: XLEN] = q;
    end

    // Read ports: array value, optional same-cycle forwarding, masked to 0 while busy or for x0.
    always_comb begin
        rd_data = '0;
        ra      = '0;
        rv      = '0;
        for (int r = 0; r < NRD_I; r++) begin
            ra = rd_addr[r*AW +: AW];
            rv = mem_flat[ra*XLEN +: XLEN];
`ifdef RF_BYPASS_EN
            for (int p = 0; p < NWR_I; p++) begin
                if (wen[p] && (wr_addr[p*AW +: AW] == ra)) begin
                    rv = wr_data[p*XLEN +: XLEN];
                end
            end
`else
            // No forwarding: a write is visible from the cycle after its posedge.
`endif
            if (busy || ((ZERO_REG != 0) && (ra == '0))) begin
                rv = '0;
            end
            rd_data[r*XLEN +: XLEN] = rv;
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: two configurations driven side by side against a behavioural model.
// Latency: inputs change 1ns after posedge, outputs are sampled at negedge.
// Backpressure: none; all loops are fixed-length.
module tb_rf_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst     = 1'b1;
    logic clr_req = 1'b0;

    // Generic stimulus per instance: [inst][port]
    logic [1:0]  s_we [2];
    logic [4:0]  s_wa [2][2];
    logic [63:0] s_wd [2][2];
    logic [4:0]  s_ra [2][4];

    // Instance A: XLEN=32 NREGS=32 NRD=2 NWR=2 ZERO_REG=1
    logic [1:0]   we_a;
    logic [9:0]   wa_a;
    logic [63:0]  wd_a;
    logic [9:0]   ra_a;
    logic [63:0]  rd_a;
    logic         busy_a;
    // Instance B: XLEN=64 NREGS=16 NRD=4 NWR=2 ZERO_REG=0
    logic [1:0]   we_b;
    logic [7:0]   wa_b;
    logic [127:0] wd_b;
    logic [15:0]  ra_b;
    logic [255:0] rd_b;
    logic         busy_b;

    assign we_a = s_we[0];
    assign wa_a = {s_wa[0][1], s_wa[0][0]};
    assign wd_a = {s_wd[0][1][31:0], s_wd[0][0][31:0]};
    assign ra_a = {s_ra[0][1], s_ra[0][0]};
    assign we_b = s_we[1];
    assign wa_b = {s_wa[1][1][3:0], s_wa[1][0][3:0]};
    assign wd_b = {s_wd[1][1], s_wd[1][0]};
    assign ra_b = {s_ra[1][3][3:0], s_ra[1][2][3:0], s_ra[1][1][3:0], s_ra[1][0][3:0]};

    logic [63:0] obs [2][4];
    logic        obs_busy [2];
    assign obs[0][0] = {32'h0, rd_a[31:0]};
    assign obs[0][1] = {32'h0, rd_a[63:32]};
    assign obs[0][2] = 64'h0;
    assign obs[0][3] = 64'h0;
    assign obs[1][0] = rd_b[63:0];
    assign obs[1][1] = rd_b[127:64];
    assign obs[1][2] = rd_b[191:128];
    assign obs[1][3] = rd_b[255:192];
    assign obs_busy[0] = busy_a;
    assign obs_busy[1] = busy_b;

    rf_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .we(we_a), .wr_addr(wa_a),
        .wr_data(wd_a), .rd_addr(ra_a), .rd_data(rd_a), .busy(busy_a)
    );

    rf_multiport #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(2), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .we(we_b), .wr_addr(wa_b),
        .wr_data(wd_b), .rd_addr(ra_b), .rd_data(rd_b), .busy(busy_b)
    );

    // Per-instance configuration
    int          nregs [2] = '{32, 16};
    int          nrd   [2] = '{2, 4};
    int          zr    [2] = '{1, 0};
    logic [63:0] dmask [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    // Model: register contents and remaining busy cycles
    logic [63:0] m [2][32];
    int          rem [2];
    int          started = 0;
    int          bcnt [2];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] vals [16];
    logic [63:0] byp_exp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] exp_rd(input int i, input int a);
        logic [63:0] v;
        if (rem[i] > 0) return 64'h0;
        if (zr[i] != 0 && a == 0) return 64'h0;
        v = m[i][a];
`ifdef RF_BYPASS_EN
        if (!rst) begin
            for (int p = 0; p < 2; p++)
                if (s_we[i][p] && int'(s_wa[i][p]) == a) v = s_wd[i][p] & dmask[i];
        end
`endif
        return v;
    endfunction

    task automatic wipe(input int i);
        for (int a = 0; a < 32; a++) m[i][a] = 64'h0;
        rem[i] = nregs[i];
    endtask

    // Negedge: compare busy and every read port against the model.
    task automatic check_cycle();
        @(negedge clk);
        if (started != 0) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy%0d", i), {63'h0, obs_busy[i]}, {63'h0, rem[i] > 0});
                bcnt[i] += int'(obs_busy[i]);
                for (int r = 0; r < nrd[i]; r++)
                    chk($sformatf("rd%0d_p%0d_a%0d", i, r, s_ra[i][r]), obs[i][r],
                        exp_rd(i, int'(s_ra[i][r])));
            end
        end
    endtask

    // Posedge: apply reset / sweep / write rules to the model.
    task automatic adv();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                wipe(i);
            end else if (rem[i] > 0) begin
                rem[i]--;
            end else begin
                for (int p = 0; p < 2; p++)
                    if (s_we[i][p] && !(zr[i] != 0 && s_wa[i][p] == 5'd0))
                        m[i][s_wa[i][p]] = s_wd[i][p] & dmask[i];
                if (clr_req) wipe(i);
            end
        end
        if (rst) started = 1;
        #1;
    endtask

    task automatic cyc();
        check_cycle();
        adv();
    endtask

    task automatic rand_inputs(input bit wr);
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                s_we[i][p] = wr ? 1'($urandom_range(0, 1)) : 1'b0;
                s_wa[i][p] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3))
                                                         : 5'($urandom_range(0, nregs[i] - 1));
                s_wd[i][p] = {32'($urandom), 32'($urandom)} & dmask[i];
            end
            for (int r = 0; r < 4; r++)
                s_ra[i][r] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3))
                                                         : 5'($urandom_range(0, nregs[i] - 1));
        end
    endtask

    task automatic quiet();
        for (int i = 0; i < 2; i++) begin
            s_we[i] = 2'b00;
            for (int p = 0; p < 2; p++) begin s_wa[i][p] = 5'd0; s_wd[i][p] = 64'h0; end
            for (int r = 0; r < 4; r++) s_ra[i][r] = 5'd0;
        end
    endtask

    initial begin
        quiet();
        for (int i = 0; i < 2; i++) begin wipe(i); bcnt[i] = 0; end

        // 1: reset held 3 cycles, then the post-reset sweep
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        bcnt[0] = 0; bcnt[1] = 0;
        for (int k = 0; k < 40; k++) begin rand_inputs(1'b0); cyc(); end
        chk("busy_len_a", 64'(bcnt[0]), 64'd32);
        chk("busy_len_b", 64'(bcnt[1]), 64'd16);
        quiet();
        for (int k = 0; k < 16; k++) begin
            s_ra[0][0] = 5'(2 * k); s_ra[0][1] = 5'(2 * k + 1);
            for (int r = 0; r < 4; r++) s_ra[1][r] = 5'((4 * k + r) % 16);
            cyc();
        end

        // 2: write x5, same-cycle and next-cycle read
        quiet();
        s_we[0] = 2'b01; s_wa[0][0] = 5'd5; s_wd[0][0] = 64'hDEAD_BEEF;
        s_ra[0][0] = 5'd5; s_ra[0][1] = 5'd5;
        check_cycle();
`ifdef RF_BYPASS_EN
        byp_exp = 64'hDEAD_BEEF;
`else
        byp_exp = 64'h0;
`endif
        chk("x5_same_cycle", obs[0][0], byp_exp);
        adv();
        s_we[0] = 2'b00;
        check_cycle();
        chk("x5_next_cycle", obs[0][1], 64'hDEAD_BEEF);
        adv();

        // 3: x0 write on both configurations
        quiet();
        s_we[0] = 2'b01; s_wd[0][0] = 64'h1234;
        s_we[1] = 2'b01; s_wd[1][0] = 64'h1234;
        cyc();
        quiet();
        check_cycle();
        chk("x0_zero_reg1", obs[0][0], 64'h0);
        chk("x0_zero_reg0", obs[1][0], 64'h1234);
        adv();

        // 4: collision on x7, higher port wins
        for (int i = 0; i < 2; i++) begin
            s_we[i] = 2'b11;
            s_wa[i][0] = 5'd7; s_wd[i][0] = 64'd1;
            s_wa[i][1] = 5'd7; s_wd[i][1] = 64'd2;
            s_ra[i][0] = 5'd7;
        end
        check_cycle();
`ifdef RF_BYPASS_EN
        byp_exp = 64'd2;
`else
        byp_exp = 64'h0;
`endif
        chk("x7_collide_same", obs[0][0], byp_exp);
        adv();
        quiet();
        s_ra[0][0] = 5'd7; s_ra[1][0] = 5'd7;
        check_cycle();
        chk("x7_collide_a", obs[0][0], 64'd2);
        chk("x7_collide_b", obs[1][0], 64'd2);
        adv();

        // 5: clr_req, reset at cnt=10, writes during busy are lost
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin rand_inputs(1'b1); clr_req = 1'b1; cyc(); end
        clr_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bcnt[0] = 0; bcnt[1] = 0;
        for (int k = 0; k < 40; k++) begin
            rand_inputs(1'b1);
            if (k < 30) begin s_we[0] = 2'b11; end
            cyc();
        end
        chk("midsweep_busy_a", 64'(bcnt[0]), 64'd32);
        chk("midsweep_busy_b", 64'(bcnt[1]), 64'd16);
        rst = 1'b1; cyc(); rst = 1'b0;
        quiet();
        repeat (33) cyc();

        // 6: fill all 16 registers of the wide configuration, read on every port
        quiet();
        for (int k = 0; k < 16; k++) vals[k] = {32'($urandom), 24'($urandom), 8'(k)};
        for (int k = 0; k < 8; k++) begin
            s_we[1] = 2'b11;
            s_wa[1][0] = 5'(2 * k);     s_wd[1][0] = vals[2 * k];
            s_wa[1][1] = 5'(2 * k + 1); s_wd[1][1] = vals[2 * k + 1];
            cyc();
        end
        quiet();
        for (int k = 0; k < 16; k++) begin
            for (int r = 0; r < 4; r++) s_ra[1][r] = 5'((k + 4 * r) % 16);
            check_cycle();
            for (int r = 0; r < 4; r++)
                chk($sformatf("fill_p%0d_r%0d", r, (k + 4 * r) % 16), obs[1][r], vals[(k + 4 * r) % 16]);
            adv();
        end

        // 7: random traffic with occasional clears and resets
        for (int k = 0; k < 400; k++) begin
            rand_inputs(1'b1);
            clr_req = ($urandom_range(0, 79) == 0);
            rst     = ($urandom_range(0, 249) == 0);
            cyc();
        end
        rst = 1'b0; clr_req = 1'b0;
        quiet();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
